// File: rtl/sseg_scan_ctrl.sv
// Four-digit seven-segment scan controller: rotates the shared cathode bus across the
// anodes, with guard blanking, leading-zero suppression and frame-synchronous double buffering.
module sseg_scan_ctrl #(
  parameter int CLK_DIV  = 25000,
  parameter int GUARD    = 4,
  parameter int BLANK_LZ = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [15:0] wr_data,
  input  logic [3:0]  dp_in,
  output logic        pend,
  output logic        frame_done,
  output logic [3:0]  an,
  output logic [7:0]  segs
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLK_DIV - 2);
  localparam logic [CNT_W-1:0] CNT_GRD  = CNT_W'(GUARD);

  typedef enum logic [1:0] {DIG0, DIG1, DIG2, DIG3} digit_t;

  digit_t           r_idx, w_idx_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             w_wrap, w_swap;

  logic [15:0] r_disp, r_pend_data;
  logic [3:0]  r_disp_dp, r_pend_dp;
  logic        r_pend;

  logic [1:0]  w_sel;
  logic [15:0] w_upper;
  logic        w_blank, w_dp;
  logic [3:0]  w_an_nxt;
  logic [7:0]  w_segs_nxt;
  logic [3:0]  r_an;
  logic [7:0]  r_segs;
  logic        r_frame_done;

  function automatic logic [6:0] hex_pattern(input logic [3:0] n);
    case (n)
      4'h0: hex_pattern = 7'h40;
      4'h1: hex_pattern = 7'h79;
      4'h2: hex_pattern = 7'h24;
      4'h3: hex_pattern = 7'h30;
      4'h4: hex_pattern = 7'h19;
      4'h5: hex_pattern = 7'h12;
      4'h6: hex_pattern = 7'h02;
      4'h7: hex_pattern = 7'h78;
      4'h8: hex_pattern = 7'h00;
      4'h9: hex_pattern = 7'h10;
      4'hA: hex_pattern = 7'h08;
      4'hB: hex_pattern = 7'h03;
      4'hC: hex_pattern = 7'h46;
      4'hD: hex_pattern = 7'h21;
      4'hE: hex_pattern = 7'h06;
      default: hex_pattern = 7'h0E;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_idx <= DIG0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_idx <= w_idx_nxt;
    end
  end

  always_comb begin
    w_wrap    = (r_cnt == CNT_LAST);
    w_cnt_nxt = w_wrap ? '0 : r_cnt + 1'b1;
    w_idx_nxt = r_idx;
    if (w_wrap) begin
      case (r_idx)
        DIG0:    w_idx_nxt = DIG1;
        DIG1:    w_idx_nxt = DIG2;
        DIG2:    w_idx_nxt = DIG3;
        default: w_idx_nxt = DIG0;
      endcase
    end
    w_swap = w_wrap && (r_idx == DIG3);
  end

  // Pending/display double buffer; a write coincident with the swap stays pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend_data <= '0;
      r_pend_dp   <= '0;
      r_pend      <= 1'b0;
      r_disp      <= '0;
      r_disp_dp   <= '0;
    end else begin
      if (wr_en) begin
        r_pend_data <= wr_data;
        r_pend_dp   <= dp_in;
        r_pend      <= 1'b1;
      end else if (w_swap) begin
        r_pend      <= 1'b0;
      end
      if (w_swap && r_pend) begin
        r_disp    <= r_pend_data;
        r_disp_dp <= r_pend_dp;
      end
    end
  end

  always_comb begin
    w_sel      = r_idx;
    w_upper    = r_disp >> {w_sel, 2'b00};
    w_dp       = r_disp_dp[w_sel];
    w_blank    = (BLANK_LZ != 0) && (w_sel != 2'd0) && (w_upper == 16'h0000);
    w_an_nxt   = 4'hF;
    w_segs_nxt = 8'hFF;
    if (r_cnt >= CNT_GRD) begin
      w_an_nxt   = ~(4'b0001 << w_sel);
      w_segs_nxt = {~w_dp, w_blank ? 7'h7F : hex_pattern(w_upper[3:0])};
    end
  end

  // Output stage: frame_done is registered one cycle early so it lands on the swap slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_an         <= 4'hF;
      r_segs       <= 8'hFF;
      r_frame_done <= 1'b0;
    end else begin
      r_an         <= w_an_nxt;
      r_segs       <= w_segs_nxt;
      r_frame_done <= (r_idx == DIG3) && (r_cnt == CNT_PRE);
    end
  end

  assign an         = r_an;
  assign segs       = r_segs;
  assign frame_done = r_frame_done;
  assign pend       = r_pend;

endmodule
